// File: rtl/apb_slave_pkg.sv
// apb_slave_regfile shared types and constants.
// FSM state encoding, counter width, bus widths.
package apb_slave_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS_WAIT,
        ACCESS_DONE
    } apb_slv_state_e;

    localparam int CNT_W  = 4;
    localparam int APB_AW = 8;
    localparam int APB_DW = 8;

endpackage

// File: rtl/apb_slave_if.sv
// APB completer-side bus bundle.
// master drives the request, slave drives the response.
interface apb_slave_if
    import apb_slave_pkg::*;
#(
    parameter int AW = APB_AW,
    parameter int DW = APB_DW
) ();

    logic          psel;
    logic          penable;
    logic          pwrite;
    logic [AW-1:0] paddr;
    logic [DW-1:0] pwdata;
    logic [DW-1:0] prdata;
    logic          pready;
    logic          pslverr;

    modport master (
        output psel, penable, pwrite, paddr, pwdata,
        input  prdata, pready, pslverr
    );

    modport slave (
        input  psel, penable, pwrite, paddr, pwdata,
        output prdata, pready, pslverr
    );

endinterface

// File: rtl/apb_regfile_mem.sv
// DEPTH x DW register storage.
// Sync write and clear, combinational read.
module apb_regfile_mem #(
    parameter int DW    = 8,
    parameter int DEPTH = 64,
    parameter int IW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic          pclk,
    input  logic          presetn,
    input  logic          we,
    input  logic [IW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [IW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [DEPTH];

    // Clear on reset, otherwise commit the write.
    always_ff @(posedge pclk) begin
        if (!presetn) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/apb_slave_regfile.sv
// APB completer with register file and wait states.
// Registered responses; out-of-range addresses flag pslverr.
module apb_slave_regfile
    import apb_slave_pkg::*;
#(
    parameter int AW          = APB_AW,
    parameter int DW          = APB_DW,
    parameter int DEPTH       = 64,
    parameter int WAIT_CYCLES = 0
) (
    input  logic       pclk,
    input  logic       presetn,
    apb_slave_if.slave bus
);

    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);
    localparam logic [CNT_W-1:0] WAIT_LD = CNT_W'(WAIT_CYCLES);

    apb_slv_state_e state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [IW-1:0]    addr_q, addr_d;
    logic             wr_q, wr_d;
    logic             err_q, err_d;
    logic [DW-1:0]    wdata_q, wdata_d;
    logic [DW-1:0]    prdata_q, prdata_d;
    logic             pready_q, pready_d;
    logic             pslverr_q, pslverr_d;

    logic          setup;
    logic          err_in;
    logic          we;
    logic [IW-1:0] raddr;
    logic [DW-1:0] rdata;

    assign setup  = bus.psel & ~bus.penable;
    assign err_in = {1'b0, bus.paddr} >= DEPTH_W;
    assign we     = (state_q == ACCESS_DONE) & wr_q & ~err_q;
    assign raddr  = (state_q == IDLE) ? bus.paddr[IW-1:0] : addr_q;

    apb_regfile_mem #(
        .DW    (DW),
        .DEPTH (DEPTH),
        .IW    (IW)
    ) u_mem (
        .pclk    (pclk),
        .presetn (presetn),
        .we      (we),
        .waddr   (addr_q),
        .wdata   (wdata_q),
        .raddr   (raddr),
        .rdata   (rdata)
    );

    // Next state and next registered response.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        addr_d    = addr_q;
        wr_d      = wr_q;
        err_d     = err_q;
        wdata_d   = wdata_q;
        prdata_d  = '0;
        pready_d  = 1'b0;
        pslverr_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (setup) begin
                    addr_d  = bus.paddr[IW-1:0];
                    wr_d    = bus.pwrite;
                    err_d   = err_in;
                    wdata_d = bus.pwdata;
                    if (WAIT_CYCLES == 0) begin
                        state_d   = ACCESS_DONE;
                        pready_d  = 1'b1;
                        pslverr_d = err_in;
                        if (!bus.pwrite && !err_in) begin
                            prdata_d = rdata;
                        end
                    end else begin
                        state_d = ACCESS_WAIT;
                        cnt_d   = WAIT_LD;
                    end
                end
            end
            ACCESS_WAIT: begin
                if (!bus.psel) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (bus.penable) begin
                    if (cnt_q == CNT_W'(1)) begin
                        state_d   = ACCESS_DONE;
                        cnt_d     = '0;
                        pready_d  = 1'b1;
                        pslverr_d = err_q;
                        if (!wr_q && !err_q) begin
                            prdata_d = rdata;
                        end
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
            end
            ACCESS_DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and response registers; reset wins over any transfer.
    always_ff @(posedge pclk) begin
        if (!presetn) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            addr_q    <= '0;
            wr_q      <= 1'b0;
            err_q     <= 1'b0;
            wdata_q   <= '0;
            prdata_q  <= '0;
            pready_q  <= 1'b0;
            pslverr_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            addr_q    <= addr_d;
            wr_q      <= wr_d;
            err_q     <= err_d;
            wdata_q   <= wdata_d;
            prdata_q  <= prdata_d;
            pready_q  <= pready_d;
            pslverr_q <= pslverr_d;
        end
    end

    assign bus.prdata  = prdata_q;
    assign bus.pready  = pready_q;
    assign bus.pslverr = pslverr_q;

endmodule

// File: tb/tb_apb_slave_regfile.sv
// Bench for apb_slave_regfile: three instances with
// WAIT_CYCLES 0, 2 and 3 behind one shared request bus.
module tb_apb_slave_regfile;

    logic       pclk = 1'b0;
    logic       presetn = 1'b0;
    logic       psel = 1'b0;
    logic       penable = 1'b0;
    logic       pwrite = 1'b0;
    logic [7:0] paddr = '0;
    logic [7:0] pwdata = '0;
    int         sel = 0;

    logic [7:0] prdata;
    logic       pready;
    logic       pslverr;

    int n_chk = 0;
    int n_err = 0;

    logic [7:0] model [4][64];

    typedef struct {
        logic       wr;
        logic [7:0] data;
        logic       err;
        int         lat;
    } exp_t;

    exp_t sb[$];

    always #5 pclk = ~pclk;

    apb_slave_if #(.AW(8), .DW(8)) if0 ();
    apb_slave_if #(.AW(8), .DW(8)) if2 ();
    apb_slave_if #(.AW(8), .DW(8)) if3 ();

    assign if0.psel    = psel && (sel == 0);
    assign if0.penable = penable;
    assign if0.pwrite  = pwrite;
    assign if0.paddr   = paddr;
    assign if0.pwdata  = pwdata;
    assign if2.psel    = psel && (sel == 2);
    assign if2.penable = penable;
    assign if2.pwrite  = pwrite;
    assign if2.paddr   = paddr;
    assign if2.pwdata  = pwdata;
    assign if3.psel    = psel && (sel == 3);
    assign if3.penable = penable;
    assign if3.pwrite  = pwrite;
    assign if3.paddr   = paddr;
    assign if3.pwdata  = pwdata;

    apb_slave_regfile #(.AW(8), .DW(8), .DEPTH(64), .WAIT_CYCLES(0)) u0 (
        .pclk (pclk), .presetn (presetn), .bus (if0)
    );
    apb_slave_regfile #(.AW(8), .DW(8), .DEPTH(64), .WAIT_CYCLES(2)) u2 (
        .pclk (pclk), .presetn (presetn), .bus (if2)
    );
    apb_slave_regfile #(.AW(8), .DW(8), .DEPTH(64), .WAIT_CYCLES(3)) u3 (
        .pclk (pclk), .presetn (presetn), .bus (if3)
    );

    always_comb begin
        prdata  = if0.prdata;
        pready  = if0.pready;
        pslverr = if0.pslverr;
        if (sel == 2) begin
            prdata  = if2.prdata;
            pready  = if2.pready;
            pslverr = if2.pslverr;
        end else if (sel == 3) begin
            prdata  = if3.prdata;
            pready  = if3.pready;
            pslverr = if3.pslverr;
        end
    end

    task automatic check(input string tag, input logic [31:0] act,
                         input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s sel=%0d got=%h want=%h t=%0t",
                     tag, sel, act, exp, $time);
        end
    endtask

    task automatic clear_model();
        for (int s = 0; s < 4; s++) begin
            for (int i = 0; i < 64; i++) begin
                model[s][i] = 8'h00;
            end
        end
    endtask

    task automatic xfer(input logic wr, input logic [7:0] a,
                        input logic [7:0] d);
        exp_t e;
        int   cyc;
        e.wr   = wr;
        e.err  = (a >= 8'd64);
        e.lat  = sel + 1;
        e.data = (wr || e.err) ? 8'h00 : model[sel][a[5:0]];
        if (wr && !e.err) begin
            model[sel][a[5:0]] = d;
        end
        sb.push_back(e);
        @(posedge pclk); #1;
        psel    = 1'b1;
        penable = 1'b0;
        pwrite  = wr;
        paddr   = a;
        pwdata  = d;
        check("idle_pready", {31'd0, pready}, 32'd0);
        @(posedge pclk); #1;
        penable = 1'b1;
        paddr   = ~a;
        pwdata  = ~d;
        pwrite  = ~wr;
        cyc = 1;
        while (!pready && cyc <= 20) begin
            @(posedge pclk); #1;
            cyc++;
        end
        e = sb.pop_front();
        if (!pready) begin
            check("timeout", {31'd0, pready}, 32'd1);
        end else begin
            check("latency", cyc, e.lat);
            check("pslverr", {31'd0, pslverr}, {31'd0, e.err});
            if (!e.wr) begin
                check("prdata", {24'd0, prdata}, {24'd0, e.data});
            end
        end
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge pclk); #1;
            psel    = 1'b0;
            penable = 1'b0;
            check("idle_low", {31'd0, pready}, 32'd0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1);
    end

    initial begin
        clear_model();
        presetn = 1'b0;
        repeat (2) @(posedge pclk);
        #1;
        for (int s = 0; s < 4; s++) begin
            if (s != 1) begin
                sel = s;
                #0;
                check("rst_pready", {31'd0, pready}, 32'd0);
                check("rst_pslverr", {31'd0, pslverr}, 32'd0);
                check("rst_prdata", {24'd0, prdata}, 32'd0);
            end
        end
        presetn = 1'b1;
        sel = 0;

        xfer(1'b0, 8'h05, 8'h00);
        xfer(1'b1, 8'h10, 8'hA5);
        xfer(1'b0, 8'h10, 8'h00);
        idle(1);

        @(posedge pclk); #1;
        psel    = 1'b1;
        penable = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(posedge pclk); #1;
            check("no_setup", {31'd0, pready}, 32'd0);
        end
        idle(1);

        xfer(1'b1, 8'h40, 8'hFF);
        xfer(1'b0, 8'h40, 8'h00);
        xfer(1'b0, 8'h00, 8'h00);
        xfer(1'b0, 8'h3F, 8'h00);
        xfer(1'b1, 8'h3F, 8'h5A);
        xfer(1'b0, 8'h3F, 8'h00);
        xfer(1'b1, 8'hFF, 8'h11);
        xfer(1'b0, 8'hFF, 8'h00);
        xfer(1'b0, 8'h10, 8'h00);
        idle(1);

        sel = 3;
        xfer(1'b1, 8'h20, 8'h3C);
        xfer(1'b0, 8'h20, 8'h00);
        xfer(1'b0, 8'h10, 8'h00);
        idle(1);

        sel = 2;
        @(posedge pclk); #1;
        psel    = 1'b1;
        penable = 1'b0;
        pwrite  = 1'b1;
        paddr   = 8'h08;
        pwdata  = 8'h77;
        @(posedge pclk); #1;
        penable = 1'b1;
        check("abort_wait", {31'd0, pready}, 32'd0);
        @(posedge pclk); #1;
        psel    = 1'b0;
        penable = 1'b0;
        check("abort_wait2", {31'd0, pready}, 32'd0);
        for (int k = 0; k < 3; k++) begin
            @(posedge pclk); #1;
            check("abort_rdy", {31'd0, pready}, 32'd0);
            check("abort_err", {31'd0, pslverr}, 32'd0);
        end
        xfer(1'b0, 8'h08, 8'h00);
        xfer(1'b1, 8'h08, 8'h12);
        xfer(1'b0, 8'h08, 8'h00);
        idle(1);

        sel = 0;
        @(posedge pclk); #1;
        psel    = 1'b1;
        penable = 1'b0;
        pwrite  = 1'b1;
        paddr   = 8'h01;
        pwdata  = 8'h99;
        @(posedge pclk); #1;
        penable = 1'b1;
        check("mid_done", {31'd0, pready}, 32'd1);
        presetn = 1'b0;
        psel    = 1'b0;
        penable = 1'b0;
        @(posedge pclk); #1;
        check("mid_rst", {31'd0, pready}, 32'd0);
        presetn = 1'b1;
        clear_model();
        xfer(1'b0, 8'h01, 8'h00);
        xfer(1'b0, 8'h10, 8'h00);
        xfer(1'b0, 8'h3F, 8'h00);
        idle(1);

        sel = 3;
        xfer(1'b0, 8'h20, 8'h00);
        idle(2);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
